subtractor_32_serial: RTL

- Multi-cycle 32-bit subtractor computing input_1 - input_2 - borrow_in. It processes one 4-bit digit per clock, from LSB to MSB, so it is the subtract/borrow counterpart of the 32-bit nibble-chained adder.
- The PageRank datapath uses it to form rank deltas between iterations (old minus new) for convergence checks.
- Operands arrive on a valid/ready request handshake; the difference leaves on a valid/ready response handshake.

---
 rtl/subtractor_32_serial.sv | 135 +++++++++++++
 1 files changed

// File: rtl/subtractor_32_serial.sv
// Digit-serial subtractor: computes input_1 - input_2 - borrow_in one DIGIT-wide
// slice per clock, LSB first, behind valid/ready request and response handshakes.
module subtractor_32_serial #(
    parameter int WIDTH = 32,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] input_1,
    input  logic [WIDTH-1:0] input_2,
    input  logic             borrow_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] difference,
    output logic             borrow
);

    localparam int NDIG  = WIDTH / DIGIT;
    localparam int CNT_W = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [CNT_W-1:0] LAST_DIGIT = CNT_W'(NDIG - 1);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

    state_t             state_r;
    state_t             state_s;
    logic [WIDTH-1:0]   a_r;
    logic [WIDTH-1:0]   b_r;
    logic [WIDTH-1:0]   diff_r;
    logic               brw_r;
    logic               borrow_r;
    logic               in_ready_r;
    logic               out_valid_r;
    logic [CNT_W-1:0]   cnt_r;
    logic [DIGIT:0]     t_s;
    logic               accept_s;
    logic               last_s;

    assign accept_s   = in_valid && in_ready_r;
    assign last_s     = (cnt_r == LAST_DIGIT);
    assign in_ready   = in_ready_r;
    assign out_valid  = out_valid_r;
    assign difference = diff_r;
    assign borrow     = borrow_r;

    // Digit slice: operands are shifted right each RUN cycle, so the live digit is always at the bottom.
    always_comb begin
        t_s = {1'b0, a_r[DIGIT-1:0]} - {1'b0, b_r[DIGIT-1:0]} - {{DIGIT{1'b0}}, brw_r};
    end

    // Next-state logic for the request/compute/hold sequence.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    state_s = RUN;
                end else begin
                    state_s = IDLE;
                end
            end
            RUN: begin
                if (last_s) begin
                    state_s = DONE;
                end else begin
                    state_s = RUN;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_s = IDLE;
                end else begin
                    state_s = DONE;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State register with handshake flags registered from the next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= IDLE;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
        end else begin
            state_r     <= state_s;
            in_ready_r  <= (state_s == IDLE);
            out_valid_r <= (state_s == DONE);
        end
    end

    // Operand capture and digit-serial datapath; the result shifts in from the MSB end.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_r      <= {WIDTH{1'b0}};
            b_r      <= {WIDTH{1'b0}};
            diff_r   <= {WIDTH{1'b0}};
            brw_r    <= 1'b0;
            borrow_r <= 1'b0;
            cnt_r    <= {CNT_W{1'b0}};
        end else begin
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        a_r   <= input_1;
                        b_r   <= input_2;
                        brw_r <= borrow_in;
                        cnt_r <= {CNT_W{1'b0}};
                    end
                end
                RUN: begin
                    a_r    <= a_r >> DIGIT;
                    b_r    <= b_r >> DIGIT;
                    diff_r <= {t_s[DIGIT-1:0], diff_r[WIDTH-1:DIGIT]};
                    brw_r  <= t_s[DIGIT];
                    cnt_r  <= last_s ? {CNT_W{1'b0}} : cnt_r + CNT_W'(1);
                    if (last_s) begin
                        borrow_r <= t_s[DIGIT];
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
